// File: rtl/ifq_pkg.sv
// Shared types for the instruction prefetch queue: FSM states, queue entry
// layout and the word-increment helper used for fetch/response PC tracking.
package ifq_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifq_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc_plus4;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of DEPTH instruction entries with push/pop/clear.
// Pointers wrap naturally because DEPTH is a power of two.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  ifq_entry_t                 i_data,
  output ifq_entry_t                 o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ifq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // A push into a full queue is fine when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between imem and IF/ID with redirect flush.
// Optional macro IFQ_BYPASS_EN: forward a response straight to IF/ID when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_plus4_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  ifq_state_t       r_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;

  ifq_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_drop_nxt;
  logic [CNT_W-1:0] w_outst_after_rsp;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  ifq_entry_t       w_head;
  ifq_entry_t       w_push_data;
  logic [SUM_W-1:0] w_inflight;
  logic             w_credit;
  logic             w_req_fire;
  logic             w_rsp_live;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  // Credit: every issued request must have a guaranteed slot when it returns.
  assign w_inflight     = SUM_W'(w_count) + SUM_W'(r_outstanding);
  assign w_credit       = (w_inflight < SUM_W'(DEPTH));
  assign imem_req_valid = !rst && !redirect && w_credit;
  assign imem_addr      = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response is useful only in FETCH and only if no flush is happening now.
  assign w_rsp_live  = imem_rsp_valid && !rst && !redirect && (r_state == FETCH);
  assign w_push_data = '{inst: imem_rsp_data, pc_plus4: next_word(r_rsp_pc)};

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_rsp_live && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_rsp_live && !(w_bypass && inst_ready) && (!w_full || w_pop);
  assign w_pop  = inst_ready && !redirect && !w_empty;

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clear(redirect),
    .i_data (w_push_data),
    .o_head (w_head),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    if (w_bypass) begin
      inst_valid   = 1'b1;
      inst_out     = w_push_data.inst;
      pc_plus4_out = w_push_data.pc_plus4;
    end else begin
      inst_valid   = !w_empty;
      inst_out     = w_empty ? 32'h0 : w_head.inst;
      pc_plus4_out = w_empty ? 32'h0 : w_head.pc_plus4;
    end
  end

  // Fetch / response PC counters and outstanding request tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
      end else begin
        if (w_req_fire) r_fetch_pc <= next_word(r_fetch_pc);
        if (w_rsp_live) r_rsp_pc   <= next_word(r_rsp_pc);
      end
      case ({w_req_fire, imem_rsp_valid})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // Requests still in flight at a redirect return stale data and are dropped.
  always_comb begin
    w_state_nxt       = r_state;
    w_drop_nxt        = r_drop_cnt;
    w_outst_after_rsp = r_outstanding - CNT_W'(imem_rsp_valid);
    if (redirect) begin
      w_drop_nxt  = w_outst_after_rsp;
      w_state_nxt = (w_outst_after_rsp != '0) ? DRAIN : FETCH;
    end else if ((r_state == DRAIN) && imem_rsp_valid) begin
      w_drop_nxt = r_drop_cnt - CNT_W'(1);
      if (r_drop_cnt == CNT_W'(1)) w_state_nxt = FETCH;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: fixed-latency in-order memory model,
// inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_plus4_out;
  logic        redirect;
  logic [31:0] redirect_pc;

  ifetch_queue #(
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .pc_plus4_out  (pc_plus4_out),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  int          cyc;
  int          lat;
  int          n_checks;
  int          n_errors;
  logic        s_req;
  logic        s_iv;
  logic [31:0] s_addr;
  logic [31:0] s_inst;
  logic [31:0] s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input logic t_rst, input logic t_rdir, input logic [31:0] t_rpc,
                      input logic t_ird);
    @(negedge clk);
    rst         = t_rst;
    redirect    = t_rdir;
    redirect_pc = t_rpc;
    inst_ready  = t_ird;
    if (t_rst) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    s_req  = imem_req_valid;
    s_iv   = inst_valid;
    s_addr = imem_addr;
    s_inst = inst_out;
    s_pc4  = pc_plus4_out;
    if (imem_req_valid && imem_req_ready) mq.push_back('{imem_addr, cyc + lat});
    cyc++;
  endtask

  task automatic step(input logic t_ird);
    tick(1'b0, 1'b0, 32'h0, t_ird);
  endtask

  task automatic do_reset(input int mem_lat);
    lat = mem_lat;
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    check("rst_req_valid", 32'(s_req), 32'h0);
    check("rst_inst_valid", 32'(s_iv), 32'h0);
    check("rst_inst_out", s_inst, 32'h0);
    check("rst_pc4", s_pc4, 32'h0);
    check("rst_addr", s_addr, 32'h0);
  endtask

  task automatic wait_inst(input string tag, output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (s_iv) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'h1);
  endtask

  initial begin
    logic found;
    int   acc;
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    cyc            = 0;
    lat            = 1;
    n_checks       = 0;
    n_errors       = 0;

    // Streaming with a one-cycle memory
    do_reset(1);
    step(1'b1);
    check("s_c0_req", 32'(s_req), 32'h1);
    check("s_c0_addr", s_addr, 32'h0);
    check("s_c0_iv", 32'(s_iv), 32'h0);
    step(1'b1);
    check("s_c1_addr", s_addr, 32'h4);
    check("s_c1_iv", 32'(s_iv), 32'h0);
    step(1'b1);
    check("s_c2_iv", 32'(s_iv), 32'h1);
    check("s_c2_inst", s_inst, 32'hC0DE_0000);
    check("s_c2_pc4", s_pc4, 32'h4);
    check("s_c2_addr", s_addr, 32'h8);
    step(1'b1);
    check("s_c3_inst", s_inst, 32'hC0DE_0004);
    check("s_c3_pc4", s_pc4, 32'h8);
    step(1'b1);
    check("s_c4_iv", 32'(s_iv), 32'h1);
    check("s_c4_pc4", s_pc4, 32'hC);

    // Back-pressure: credit limits issue to DEPTH, nothing lost afterwards
    do_reset(1);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (s_req) acc++;
    end
    check("bp_req_count", 32'(acc), 32'h4);
    check("bp_req_low", 32'(s_req), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      check("bp_drain_iv", 32'(s_iv), 32'h1);
      check("bp_drain_inst", s_inst, 32'hC0DE_0000 | 32'(4 * i));
      check("bp_drain_pc4", s_pc4, 32'(4 * i + 4));
    end

    // Redirect with two requests outstanding on a 3-cycle memory
    do_reset(3);
    step(1'b1);
    step(1'b1);
    tick(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    check("rd3_noreq", 32'(s_req), 32'h0);
    step(1'b1);
    check("rd3_req", 32'(s_req), 32'h1);
    check("rd3_addr", s_addr, 32'h0000_0100);
    check("rd3_iv", 32'(s_iv), 32'h0);
    wait_inst("rd3_timeout", found);
    check("rd3_inst", s_inst, 32'hC0DE_0100);
    check("rd3_pc4", s_pc4, 32'h0000_0104);

    // Redirect coinciding with a response and a pop
    do_reset(1);
    step(1'b1);
    step(1'b1);
    tick(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    check("rdr_noreq", 32'(s_req), 32'h0);
    step(1'b1);
    check("rdr_empty", 32'(s_iv), 32'h0);
    check("rdr_req", 32'(s_req), 32'h1);
    check("rdr_addr", s_addr, 32'h0000_0200);
    step(1'b1);
    check("rdr_c4_iv", 32'(s_iv), 32'h0);
    step(1'b1);
    check("rdr_c5_iv", 32'(s_iv), 32'h1);
    check("rdr_inst", s_inst, 32'hC0DE_0200);
    check("rdr_pc4", s_pc4, 32'h0000_0204);

    // Fetch address wrap at the top of the address space
    do_reset(1);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    check("wrap_noreq", 32'(s_req), 32'h0);
    step(1'b1);
    check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    step(1'b1);
    check("wrap_addr_zero", s_addr, 32'h0000_0000);
    step(1'b1);
    check("wrap_inst", s_inst, 32'h3F21_FFFC);
    check("wrap_pc4", s_pc4, 32'h0000_0000);
    step(1'b1);
    check("wrap_inst2", s_inst, 32'hC0DE_0000);
    check("wrap_pc4_2", s_pc4, 32'h0000_0004);

    // Reset while draining stale responses
    do_reset(3);
    step(1'b1);
    step(1'b1);
    tick(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1);
    check("rdrain_addr", s_addr, 32'h0000_0000);
    check("rdrain_req", 32'(s_req), 32'h1);
    check("rdrain_iv", 32'(s_iv), 32'h0);
    wait_inst("rdrain_timeout", found);
    check("rdrain_inst", s_inst, 32'hC0DE_0000);
    check("rdrain_pc4", s_pc4, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
